// File: rtl/br_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : br_tx_arbiter
//  Purpose  : Round-robin arbiter sharing the single BrLite local service
//             port between N_REQ local requesters. One transaction at a time:
//             the winner's payload is registered onto br_data_o, br_req_o is
//             held until the router acks, then a one-cycle ack_o pulse is
//             returned to the winner, followed by one dead cycle.
//  Ports    :
//    clk_i           in   clock, rising edge
//    rst_ni          in   asynchronous active-low reset
//    req_i           in   [N_REQ]            per-requester request level
//    data_i          in   [N_REQ][PAYLOAD_W] per-requester payload
//    ack_o           out  [N_REQ]            one-cycle completion pulse
//    br_local_busy_i in   BrLite local port busy, blocks new grants
//    br_req_o        out  request to BrLite
//    br_ack_i        in   BrLite accept
//    br_data_o       out  [PAYLOAD_W] registered payload to BrLite
//    busy_o          out  transaction in flight
//    grant_idx_o     out  [IDX_W] index of current/last winner
//  Revision : 1.0  initial release
// ============================================================================
module br_tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int PAYLOAD_W = 20,   // {ksvc[3:0], payload[15:0]}
  parameter int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [N_REQ-1:0]                 req_i,
  input  logic [N_REQ-1:0][PAYLOAD_W-1:0]  data_i,
  output logic [N_REQ-1:0]                 ack_o,
  input  logic                             br_local_busy_i,
  output logic                             br_req_o,
  input  logic                             br_ack_i,
  output logic [PAYLOAD_W-1:0]             br_data_o,
  output logic                             busy_o,
  output logic [IDX_W-1:0]                 grant_idx_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_gidx;
  logic [N_REQ-1:0]     r_ack;
  logic                 r_req;
  logic [PAYLOAD_W-1:0] r_data;

  // w_scan[k] is the requester index visited k-th, starting just after the
  // last winner and wrapping modulo N_REQ.
  logic [IDX_W-1:0]     w_scan [N_REQ];
  logic [IDX_W-1:0]     w_win;
  logic                 w_any;

  for (genvar k = 0; k < N_REQ; k++) begin : g_scan
    assign w_scan[k] = IDX_W'((int'(r_ptr) + k + 1) % N_REQ);
  end

  // Walk the scan order backwards so the last assignment is the first
  // requester encountered from ptr+1 onward.
  always_comb begin
    w_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[w_scan[k]]) begin
        w_win = w_scan[k];
      end
    end
  end

  assign w_any = |req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ptr   <= IDX_W'(N_REQ - 1);
      r_gidx  <= '0;
      r_ack   <= '0;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any && !br_local_busy_i) begin
            r_gidx  <= w_win;
            r_data  <= data_i[w_win];
            r_req   <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Request withdrawal after the latch is deliberately ignored: the
          // transaction is already committed to the router.
          if (br_ack_i) begin
            r_req   <= 1'b0;
            r_ack   <= N_REQ'(1) << r_gidx;
            r_ptr   <= r_gidx;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Dead cycle lets the winner drop req_i before re-arbitration.
          r_ack   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack   <= '0;
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_o       = r_ack;
  assign br_req_o    = r_req;
  assign br_data_o   = r_data;
  assign busy_o      = (r_state != S_IDLE);
  assign grant_idx_o = r_gidx;

endmodule
`default_nettype wire

// File: tb/tb_br_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_br_tx_arbiter
//  Purpose  : Directed self-checking bench for br_tx_arbiter (N_REQ=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_br_tx_arbiter;

  localparam int N  = 2;
  localparam int PW = 20;
  localparam int IW = 1;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [N-1:0]          req_i;
  logic [N-1:0][PW-1:0]  data_i;
  logic [N-1:0]          ack_o;
  logic                  br_local_busy_i;
  logic                  br_req_o;
  logic                  br_ack_i;
  logic [PW-1:0]         br_data_o;
  logic                  busy_o;
  logic [IW-1:0]         grant_idx_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  br_tx_arbiter #(.N_REQ(N), .PAYLOAD_W(PW)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_i           (req_i),
    .data_i          (data_i),
    .ack_o           (ack_o),
    .br_local_busy_i (br_local_busy_i),
    .br_req_o        (br_req_o),
    .br_ack_i        (br_ack_i),
    .br_data_o       (br_data_o),
    .busy_o          (busy_o),
    .grant_idx_o     (grant_idx_o)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni          = 1'b0;
    req_i           = '0;
    data_i          = '0;
    br_local_busy_i = 1'b0;
    br_ack_i        = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({br_req_o, ack_o, busy_o, grant_idx_o, br_data_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b ack=%b busy=%b gidx=%0d data=%h, want all zero",
               br_req_o, ack_o, busy_o, grant_idx_o, br_data_o);
    end
  endtask

  // Single requester, router acks in cycle 3.
  task automatic test_single();
    data_i[0] = 20'h3BEEF;
    req_i     = 2'b01;
    step();   // cycle 1
    n_cmp++;
    if (br_req_o !== 1'b1 || br_data_o !== 20'h3BEEF || grant_idx_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: got req=%b data=%h gidx=%0d busy=%b, want 1 3beef 0 1",
               br_req_o, br_data_o, grant_idx_o, busy_o);
    end
    step();   // cycle 2
    step();   // cycle 3
    n_cmp++;
    if (br_req_o !== 1'b1 || ack_o !== 2'b00) begin
      n_err++;
      $display("FAIL single_hold: got req=%b ack=%b, want 1 00", br_req_o, ack_o);
    end
    br_ack_i = 1'b1;
    step();   // cycle 4
    br_ack_i = 1'b0;
    n_cmp++;
    if (br_req_o !== 1'b0 || ack_o !== 2'b01 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_ack: got req=%b ack=%b busy=%b, want 0 01 1", br_req_o, ack_o, busy_o);
    end
    req_i = 2'b00;
    step();   // cycle 5
    n_cmp++;
    if (ack_o !== 2'b00 || busy_o !== 1'b0 || br_data_o !== 20'h3BEEF) begin
      n_err++;
      $display("FAIL single_release: got ack=%b busy=%b data=%h, want 00 0 3beef",
               ack_o, busy_o, br_data_o);
    end
  endtask

  // Both requesting from reset: grants alternate 0,1,0,1.
  task automatic test_alternate();
    logic [IW-1:0] exp_g [4];
    logic [PW-1:0] pay   [2];
    int            cyc;
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    pay   = '{20'hA1111, 20'hB2222};
    apply_reset();
    data_i[0] = pay[0];
    data_i[1] = pay[1];
    req_i     = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      while (br_req_o !== 1'b1 && cyc < 8) begin
        step();
        cyc++;
        n_cmp++;
        if ($countones(ack_o) > 1) begin
          n_err++;
          $display("FAIL alt_onehot: got ack=%b, want at most one bit", ack_o);
        end
      end
      n_cmp++;
      if (br_req_o !== 1'b1) begin
        n_err++;
        $display("FAIL alt_timeout: grant %0d got no br_req_o, want 1", i);
      end
      n_cmp++;
      if (grant_idx_o !== exp_g[i] || br_data_o !== pay[exp_g[i]]) begin
        n_err++;
        $display("FAIL alt_grant%0d: got gidx=%0d data=%h, want %0d %h",
                 i, grant_idx_o, br_data_o, exp_g[i], pay[exp_g[i]]);
      end
      br_ack_i = 1'b1;
      step();
      br_ack_i = 1'b0;
      n_cmp++;
      if (ack_o !== (2'b01 << exp_g[i])) begin
        n_err++;
        $display("FAIL alt_ack%0d: got ack=%b, want %b", i, ack_o, 2'b01 << exp_g[i]);
      end
    end
    req_i = 2'b00;
    step();
    step();
  endtask

  // Local port busy blocks grants; ptr is 1 so requester 0 wins.
  task automatic test_busy();
    req_i           = 2'b01;
    br_local_busy_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (br_req_o !== 1'b0 || busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL busy_block%0d: got req=%b busy=%b, want 0 0", i, br_req_o, busy_o);
      end
    end
    br_local_busy_i = 1'b0;
    step();
    n_cmp++;
    if (br_req_o !== 1'b1 || grant_idx_o !== 1'b0) begin
      n_err++;
      $display("FAIL busy_release: got req=%b gidx=%0d, want 1 0", br_req_o, grant_idx_o);
    end
    br_local_busy_i = 1'b1;   // must be ignored during ISSUE
    br_ack_i        = 1'b1;
    step();
    br_ack_i        = 1'b0;
    br_local_busy_i = 1'b0;
    n_cmp++;
    if (ack_o !== 2'b01) begin
      n_err++;
      $display("FAIL busy_ack: got ack=%b, want 01", ack_o);
    end
    req_i = 2'b00;
    step();
    step();
  endtask

  // Requester 1 changes data and withdraws during ISSUE.
  task automatic test_withdraw();
    data_i[1] = 20'h5A5A5;
    req_i     = 2'b10;
    step();
    n_cmp++;
    if (br_req_o !== 1'b1 || grant_idx_o !== 1'b1 || br_data_o !== 20'h5A5A5) begin
      n_err++;
      $display("FAIL wd_grant: got req=%b gidx=%0d data=%h, want 1 1 5a5a5",
               br_req_o, grant_idx_o, br_data_o);
    end
    data_i[1] = 20'hFFFFF;
    req_i     = 2'b00;
    step();
    n_cmp++;
    if (br_req_o !== 1'b1 || br_data_o !== 20'h5A5A5) begin
      n_err++;
      $display("FAIL wd_frozen: got req=%b data=%h, want 1 5a5a5", br_req_o, br_data_o);
    end
    br_ack_i = 1'b1;
    step();
    br_ack_i = 1'b0;
    n_cmp++;
    if (ack_o !== 2'b10 || br_data_o !== 20'h5A5A5) begin
      n_err++;
      $display("FAIL wd_ack: got ack=%b data=%h, want 10 5a5a5", ack_o, br_data_o);
    end
    step();
    step();
  endtask

  // Reset mid-ISSUE aborts; afterwards ptr=N-1 so index 0 wins first.
  task automatic test_reset_mid();
    data_i[0] = 20'h0C0DE;
    data_i[1] = 20'h1D00D;
    req_i     = 2'b10;
    step();
    n_cmp++;
    if (br_req_o !== 1'b1 || grant_idx_o !== 1'b1) begin
      n_err++;
      $display("FAIL rm_pre: got req=%b gidx=%0d, want 1 1", br_req_o, grant_idx_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({br_req_o, ack_o, busy_o, grant_idx_o, br_data_o} !== '0) begin
      n_err++;
      $display("FAIL rm_async: got req=%b ack=%b busy=%b gidx=%0d data=%h, want all zero",
               br_req_o, ack_o, busy_o, grant_idx_o, br_data_o);
    end
    req_i = 2'b11;
    step();
    n_cmp++;
    if (ack_o !== 2'b00 || br_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL rm_held: got ack=%b req=%b, want 00 0", ack_o, br_req_o);
    end
    rst_ni = 1'b1;
    step();
    n_cmp++;
    if (br_req_o !== 1'b1 || grant_idx_o !== 1'b0 || br_data_o !== 20'h0C0DE) begin
      n_err++;
      $display("FAIL rm_first: got req=%b gidx=%0d data=%h, want 1 0 0c0de",
               br_req_o, grant_idx_o, br_data_o);
    end
    br_ack_i = 1'b1;
    step();
    br_ack_i = 1'b0;
    req_i    = 2'b00;
    step();
    step();
  endtask

  // Stray br_ack_i in IDLE and RELEASE produce nothing.
  task automatic test_stray();
    br_ack_i = 1'b1;
    step();
    step();
    n_cmp++;
    if (ack_o !== 2'b00 || busy_o !== 1'b0 || br_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL stray_idle: got ack=%b busy=%b req=%b, want 00 0 0", ack_o, busy_o, br_req_o);
    end
    br_ack_i = 1'b0;
    req_i    = 2'b01;
    step();                 // ISSUE
    br_ack_i = 1'b1;
    req_i    = 2'b00;
    step();                 // RELEASE, ack pulse; br_ack_i kept high
    n_cmp++;
    if (ack_o !== 2'b01) begin
      n_err++;
      $display("FAIL stray_pulse: got ack=%b, want 01", ack_o);
    end
    step();                 // IDLE
    n_cmp++;
    if (ack_o !== 2'b00 || busy_o !== 1'b0 || br_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL stray_release: got ack=%b busy=%b req=%b, want 00 0 0",
               ack_o, busy_o, br_req_o);
    end
    step();
    br_ack_i = 1'b0;
    n_cmp++;
    if (ack_o !== 2'b00 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL stray_after: got ack=%b busy=%b, want 00 0", ack_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_busy();
    test_withdraw();
    test_reset_mid();
    test_stray();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
